// File: rtl/board_game_engine_pkg.sv
// Shared definitions for the board game engine.
// Cell encoding, winner encoding, controller state enum and the line-scan
// direction enum together with its (row, col) step table.
package board_game_engine_pkg;

  // Cell contents; the value 3 is never written to the board.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] P1    = 2'd1;
  localparam logic [1:0] P2    = 2'd2;

  // Outcome encoding. P1_WIN/P2_WIN equal the player codes, so a win
  // latches the mover's code directly.
  localparam logic [1:0] NONE   = 2'd0;
  localparam logic [1:0] P1_WIN = 2'd1;
  localparam logic [1:0] P2_WIN = 2'd2;
  localparam logic [1:0] DRAW   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Line directions, scanned in declaration order.
  typedef enum logic [1:0] {
    DIR_H = 2'd0,
    DIR_V = 2'd1,
    DIR_D = 2'd2,
    DIR_A = 2'd3
  } dir_e;

  // Row step of the positive side of a direction.
  function automatic logic signed [1:0] dir_dr(input dir_e d);
    return (d == DIR_H) ? 2'sd0 : 2'sd1;
  endfunction

  // Column step of the positive side of a direction.
  function automatic logic signed [1:0] dir_dc(input dir_e d);
    case (d)
      DIR_H:   return 2'sd1;
      DIR_V:   return 2'sd0;
      DIR_D:   return 2'sd1;
      default: return -2'sd1;
    endcase
  endfunction

endpackage

// File: rtl/board_cell_mux.sv
// Board cell read multiplexer.
// Ports:
//   i_board  flattened board, cell (r,c) at bits [2*(r*N+c)+:2]
//   i_row    row address
//   i_col    column address
//   o_cell   selected cell, EMPTY when the address is outside the board
module board_cell_mux
  import board_game_engine_pkg::*;
#(
  parameter  int N  = 3,
  localparam int CW = $clog2(N)
) (
  input  logic [2*N*N-1:0] i_board,
  input  logic [CW-1:0]    i_row,
  input  logic [CW-1:0]    i_col,
  output logic [1:0]       o_cell
);

  always_comb begin
    o_cell = EMPTY;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if (i_row == CW'(r) && i_col == CW'(c))
          o_cell = i_board[2*(r*N+c) +: 2];
  end

endmodule

// File: rtl/board_game_engine.sv
// N x N, K-in-a-row two-player board engine.
// Accepts moves from the input logic, keeps the board and the turn, and after
// each accepted move scans the lines through the new stone one cell per cycle
// (8*(K-1) cycles) to decide win / draw / next turn.
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   new_game               synchronous clear of board and outcome
//   move_valid/move_ready  move handshake, target move_row/move_col
//   move_accept/reject     one-cycle result pulses
//   rd_row/rd_col/rd_cell  display read port (EMPTY when out of range)
//   board                  flattened board
//   turn, winner           player to move, outcome; game_over = winner != 0
module board_game_engine
  import board_game_engine_pkg::*;
#(
  parameter  int N  = 3,
  parameter  int K  = 3,
  localparam int CW = $clog2(N)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             new_game,
  input  logic             move_valid,
  output logic             move_ready,
  input  logic [CW-1:0]    move_row,
  input  logic [CW-1:0]    move_col,
  output logic             move_accept,
  output logic             move_reject,
  input  logic [CW-1:0]    rd_row,
  input  logic [CW-1:0]    rd_col,
  output logic [1:0]       rd_cell,
  output logic [2*N*N-1:0] board,
  output logic [1:0]       turn,
  output logic [1:0]       winner,
  output logic             game_over
);

  // Probe coordinates need room for -(K-1) .. 2(N-1), hence two extra bits.
  localparam int SW = CW + 2;
  localparam int RW = $clog2(2*K);
  localparam int MW = $clog2(N*N+1);
  localparam logic [CW:0]          NU        = (CW+1)'(N);
  localparam logic signed [SW-1:0] NS        = SW'(N);
  localparam logic [CW-1:0]        LAST_STEP = CW'(K-1);
  localparam logic [MW-1:0]        FULL      = MW'(N*N);
  localparam logic [RW-1:0]        KR        = RW'(K);

  state_e            r_state, w_state_nxt;
  logic [2*N*N-1:0]  r_board;
  logic [1:0]        r_turn, r_winner;
  logic [MW-1:0]     r_count;
  logic [CW-1:0]     r_row, r_col, r_step;
  dir_e              r_dir;
  logic              r_side, r_stop;
  logic [RW-1:0]     r_run [4];
  logic [RW-1:0]     w_run_nxt [4];
  logic              r_accept, r_reject;

  logic              w_accept, w_reject, w_legal, w_last, w_win, w_full;
  logic              w_in, w_hit, w_stop_eff;
  logic signed [1:0]    w_dr2, w_dc2;
  logic signed [SW-1:0] w_step_s, w_off_r, w_off_c, w_pr, w_pc;
  logic [CW-1:0]     w_probe_row, w_probe_col;
  logic [1:0]        w_probe_cell;

  // Probe position: latched move +/- step * direction.
  assign w_dr2    = dir_dr(r_dir);
  assign w_dc2    = dir_dc(r_dir);
  assign w_step_s = $signed({2'b00, r_step});
  assign w_off_r  = $signed({{(SW-2){w_dr2[1]}}, w_dr2}) * w_step_s;
  assign w_off_c  = $signed({{(SW-2){w_dc2[1]}}, w_dc2}) * w_step_s;
  assign w_pr     = r_side ? $signed({2'b00, r_row}) - w_off_r : $signed({2'b00, r_row}) + w_off_r;
  assign w_pc     = r_side ? $signed({2'b00, r_col}) - w_off_c : $signed({2'b00, r_col}) + w_off_c;
  assign w_in     = !w_pr[SW-1] && !w_pc[SW-1] && (w_pr < NS) && (w_pc < NS);

  // One mux serves both the legality check (IDLE) and the line probe (CHECK).
  assign w_probe_row = (r_state == ST_CHECK) ? w_pr[CW-1:0] : move_row;
  assign w_probe_col = (r_state == ST_CHECK) ? w_pc[CW-1:0] : move_col;

  board_cell_mux #(.N(N)) u_probe_mux (
    .i_board (r_board),
    .i_row   (w_probe_row),
    .i_col   (w_probe_col),
    .o_cell  (w_probe_cell)
  );

  board_cell_mux #(.N(N)) u_rd_mux (
    .i_board (r_board),
    .i_row   (rd_row),
    .i_col   (rd_col),
    .o_cell  (rd_cell)
  );

  assign w_legal = ({1'b0, move_row} < NU) && ({1'b0, move_col} < NU) && (w_probe_cell == EMPTY);

  // The stop flag belongs to one side; step 1 starts a fresh side.
  assign w_stop_eff = (r_step == CW'(1)) ? 1'b0 : r_stop;
  assign w_hit      = w_in && (w_probe_cell == r_turn) && !w_stop_eff;
  assign w_last     = (r_dir == DIR_A) && r_side && (r_step == LAST_STEP);
  assign w_full     = (r_count == FULL);

  always_comb begin
    w_win = 1'b0;
    for (int d = 0; d < 4; d++) begin
      w_run_nxt[d] = r_run[d];
      if (w_hit && r_dir == dir_e'(d))
        w_run_nxt[d] = r_run[d] + RW'(1);
      if (w_run_nxt[d] >= KR)
        w_win = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    if (new_game) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:
          if (move_valid) begin
            if (w_legal) begin
              w_accept    = 1'b1;
              w_state_nxt = ST_CHECK;
            end else begin
              w_reject    = 1'b1;
            end
          end
        ST_CHECK:
          if (w_last)
            w_state_nxt = (w_win || w_full) ? ST_DONE : ST_IDLE;
        ST_DONE:
          if (move_valid)
            w_reject = 1'b1;
        default:
          w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_board  <= '0;
      r_turn   <= P1;
      r_winner <= NONE;
      r_count  <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_step   <= '0;
      r_dir    <= DIR_H;
      r_side   <= 1'b0;
      r_stop   <= 1'b0;
      r_accept <= 1'b0;
      r_reject <= 1'b0;
      for (int d = 0; d < 4; d++) r_run[d] <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_accept <= w_accept;
      r_reject <= w_reject;
      if (new_game) begin
        r_board  <= '0;
        r_turn   <= P1;
        r_winner <= NONE;
        r_count  <= '0;
      end else begin
        if (w_accept) begin
          for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
              if (move_row == CW'(r) && move_col == CW'(c))
                r_board[2*(r*N+c) +: 2] <= r_turn;
          r_count <= r_count + MW'(1);
          r_row   <= move_row;
          r_col   <= move_col;
          r_dir   <= DIR_H;
          r_side  <= 1'b0;
          r_step  <= CW'(1);
          for (int d = 0; d < 4; d++) r_run[d] <= RW'(1);
        end
        if (r_state == ST_CHECK) begin
          r_stop <= !w_hit;
          for (int d = 0; d < 4; d++) r_run[d] <= w_run_nxt[d];
          // Slot order: direction, then side, then step.
          if (r_step == LAST_STEP) begin
            r_step <= CW'(1);
            r_side <= !r_side;
            if (r_side) r_dir <= dir_e'(r_dir + 2'd1);
          end else begin
            r_step <= r_step + CW'(1);
          end
          if (w_last) begin
            if (w_win)       r_winner <= r_turn;
            else if (w_full) r_winner <= DRAW;
            else             r_turn   <= (r_turn == P1) ? P2 : P1;
          end
        end
      end
    end
  end

  assign move_ready  = (r_state != ST_CHECK);
  assign move_accept = r_accept;
  assign move_reject = r_reject;
  assign board       = r_board;
  assign turn        = r_turn;
  assign winner      = r_winner;
  assign game_over   = (r_winner != NONE);

endmodule
